cmul_seq: RTL and testbench

CMUL_SEQ -- requirements
Module: cmul_seq

---
 rtl/cmul_seq.sv | 112 +++++++++++
 tb/tb_cmul_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cmul_seq.sv
// Sequential complex multiplier: one shared signed multiplier over 4 steps,
// valid/ready handshake on both sides.
module cmul_seq #(
  parameter int N = 12,
  parameter int M = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a_re,
  input  logic [N-1:0]   a_im,
  input  logic [M-1:0]   b_re,
  input  logic [M-1:0]   b_im,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+M:0]   p_re,
  output logic [N+M:0]   p_im
);

  localparam int R = N + M + 1;
  localparam int P = N + M;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]   r_step;
  logic [N-1:0] r_a_re;
  logic [N-1:0] r_a_im;
  logic [M-1:0] r_b_re;
  logic [M-1:0] r_b_im;
  logic [R-1:0] r_re;
  logic [R-1:0] r_im;

  logic                w_accept;
  logic [N-1:0]        w_ma;
  logic [M-1:0]        w_mb;
  logic signed [P-1:0] w_ma_x;
  logic signed [P-1:0] w_mb_x;
  logic signed [P-1:0] w_prod;
  logic [R-1:0]        w_prod_x;

  assign w_accept = (r_state == S_IDLE) && in_valid;

  // Step selects which cross term feeds the shared multiplier.
  always_comb begin
    w_ma = r_a_re;
    w_mb = r_b_re;
    unique case (r_step)
      2'd0: begin w_ma = r_a_re; w_mb = r_b_re; end
      2'd1: begin w_ma = r_a_im; w_mb = r_b_im; end
      2'd2: begin w_ma = r_a_re; w_mb = r_b_im; end
      2'd3: begin w_ma = r_a_im; w_mb = r_b_re; end
    endcase
  end

  assign w_ma_x   = {{M{w_ma[N-1]}}, w_ma};
  assign w_mb_x   = {{N{w_mb[M-1]}}, w_mb};
  assign w_prod   = w_ma_x * w_mb_x;
  assign w_prod_x = {w_prod[P-1], w_prod};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)        w_next = S_MUL;
      S_MUL:   if (r_step == 2'd3)  w_next = S_DONE;
      S_DONE:  if (out_ready)       w_next = S_IDLE;
      default:                      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= 2'd0;
      r_re   <= '0;
      r_im   <= '0;
    end else if (w_accept) begin
      r_a_re <= a_re;
      r_a_im <= a_im;
      r_b_re <= b_re;
      r_b_im <= b_im;
      r_re   <= '0;
      r_im   <= '0;
      r_step <= 2'd0;
    end else if (r_state == S_MUL) begin
      r_step <= r_step + 2'd1;
      unique case (r_step)
        2'd0: r_re <= r_re + w_prod_x;
        2'd1: r_re <= r_re - w_prod_x;
        2'd2: r_im <= r_im + w_prod_x;
        2'd3: r_im <= r_im + w_prod_x;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign p_re      = r_re;
  assign p_im      = r_im;

endmodule

// File: tb/tb_cmul_seq.sv
// Bench for cmul_seq: transaction-level model checked every cycle,
// plus directed vectors with literal expected results.
module tb_cmul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a_re, a_im;
  logic [12:0] b_re, b_im;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] p_re, p_im;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;

  bit     m_busy    = 1'b0;
  int     m_acc     = 0;
  longint m_re      = 0;
  longint m_im      = 0;
  int     ndone     = 0;
  bit     b2b       = 1'b0;
  bit     have_last = 1'b0;
  int     last_acc  = 0;

  cmul_seq #(.N(12), .M(13)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .p_re(p_re), .p_im(p_im)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic void chk(string nm, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endfunction

  function automatic longint sre(logic [25:0] v);
    return longint'($signed(v));
  endfunction

  // Model: one transaction in flight; result known 4 edges after accept.
  always @(negedge clk) begin
    bit ov;
    ov = m_busy && (ecnt >= m_acc + 4);
    if (ecnt > 0) begin
      chk("in_ready", longint'(in_ready), longint'(!m_busy));
      chk("out_valid", longint'(out_valid), longint'(ov));
      if (ov) begin
        chk("m_p_re", sre(p_re), m_re);
        chk("m_p_im", sre(p_im), m_im);
      end
    end
    if (rst) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        longint ar, ai, br, bi;
        ar = longint'($signed(a_re));
        ai = longint'($signed(a_im));
        br = longint'($signed(b_re));
        bi = longint'($signed(b_im));
        m_re   = ar * br - ai * bi;
        m_im   = ar * bi + ai * br;
        m_busy = 1'b1;
        m_acc  = ecnt + 1;
        if (b2b && have_last) chk("b2b_gap", m_acc - last_acc, 6);
        last_acc  = m_acc;
        have_last = 1'b1;
      end
    end else if (ov && out_ready) begin
      m_busy = 1'b0;
      ndone++;
    end
  end

  task automatic run_one(input int ar, input int ai, input int br,
                         input int bi, input longint er, input longint ei,
                         input int hold);
    int j;
    j = 0;
    while (!in_ready && j < 50) begin
      @(posedge clk); #1; j++;
    end
    chk("ready_wait", longint'(in_ready), 1);
    a_re = 12'(ar); a_im = 12'(ai);
    b_re = 13'(br); b_im = 13'(bi);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_re = ~a_re; a_im = a_im + 12'd7;
    b_re = ~b_re; b_im = b_im - 13'd3;
    j = 0;
    while (!out_valid && j < 20) begin
      @(posedge clk); #1; j++;
    end
    chk("latency", j, 4);
    chk("p_re", sre(p_re), er);
    chk("p_im", sre(p_im), ei);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", longint'(out_valid), 1);
      chk("hold_ready", longint'(in_ready), 0);
      chk("hold_re", sre(p_re), er);
      chk("hold_im", sre(p_im), ei);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ret_valid", longint'(out_valid), 0);
    chk("ret_ready", longint'(in_ready), 1);
  endtask

  function automatic logic [11:0] pick_a();
    case ($urandom_range(7))
      0:       return 12'h800;
      1:       return 12'h7FF;
      default: return 12'($urandom);
    endcase
  endfunction

  function automatic logic [12:0] pick_b();
    case ($urandom_range(7))
      0:       return 13'h1000;
      1:       return 13'h0FFF;
      default: return 13'($urandom);
    endcase
  endfunction

  initial begin
    int start, cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_p_re", sre(p_re), 0);
    chk("rst_p_im", sre(p_im), 0);
    rst = 1'b0;

    run_one(3, 4, 5, -2, 23, 14, 10);
    run_one(-2048, -2048, -4096, -4096, 0, 16777216, 0);
    run_one(2047, -2048, -4096, 4095, 2048, 16771073, 0);
    run_one(2047, 2047, -4096, -4096, 0, -16769024, 2);
    run_one(-2048, -2048, -4096, 4095, 16775168, 2048, 0);

    // Reset two edges after an accept, with in_valid still high.
    @(posedge clk); #1;
    a_re = 12'd9; a_im = 12'd9; b_re = 13'd9; b_im = 13'd9;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      chk("abort_valid", longint'(out_valid), 0);
    end
    run_one(1, 0, 0, 1, 0, 1, 0);

    // Back-to-back with operands changing every cycle.
    b2b = 1'b1; have_last = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    start = ndone;
    cyc = 0;
    while (ndone < start + 20 && cyc < 500) begin
      a_re = pick_a(); a_im = pick_a();
      b_re = pick_b(); b_im = pick_b();
      @(posedge clk); #1; cyc++;
    end
    chk("b2b_count", ndone - start, 20);
    b2b = 1'b0;

    // Random operands with random output stalls.
    start = ndone;
    cyc = 0;
    while (ndone < start + 10000 && cyc < 85000) begin
      a_re = pick_a(); a_im = pick_a();
      b_re = pick_b(); b_im = pick_b();
      in_valid  = ($urandom_range(15) != 0);
      out_ready = ($urandom_range(3) != 0);
      @(posedge clk); #1; cyc++;
    end
    chk("rand_count", ndone - start, 10000);

    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (m_busy && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("drain", longint'(m_busy), 0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
